// File: rtl/mem_ctrl_m1_if.sv
// LSU request/response and external memory bus bundle for mem_ctrl_m1.
// The slave modport is the controller; the master modport is the LSU plus memory side.
interface mem_ctrl_m1_if;
  logic [14:0] mem_address_in;
  logic [1:0]  mem_mask_in;
  logic [1:0]  mem_read_fnc_type;
  logic [15:0] mem_data_in;
  logic [1:0]  mem_mode;
  logic        mem_enable;
  logic [3:0]  mem_wb_dest;
  logic        mem_input_ready;
  logic [15:0] mem_data_out;
  logic [3:0]  mem_wb_dest_out;
  logic        mem_read_ack;
  logic        mem_available;
  logic        mem_idle;
  logic        bus_req;
  logic        bus_we;
  logic [14:0] bus_addr;
  logic [1:0]  bus_be;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;

  modport master (
    output mem_address_in, mem_mask_in, mem_read_fnc_type, mem_data_in, mem_mode,
           mem_enable, mem_wb_dest, mem_input_ready, bus_rdata, bus_ack,
    input  mem_data_out, mem_wb_dest_out, mem_read_ack, mem_available, mem_idle,
           bus_req, bus_we, bus_addr, bus_be, bus_wdata, bus_err
  );

  modport slave (
    input  mem_address_in, mem_mask_in, mem_read_fnc_type, mem_data_in, mem_mode,
           mem_enable, mem_wb_dest, mem_input_ready, bus_rdata, bus_ack,
    output mem_data_out, mem_wb_dest_out, mem_read_ack, mem_available, mem_idle,
           bus_req, bus_we, bus_addr, bus_be, bus_wdata, bus_err
  );
endinterface

// File: rtl/mem_ctrl_m1.sv
// In-order LSU data-side memory controller with a single-outstanding req/ack bus.
// Optional bus watchdog enabled by defining MEMCTL_M1_TIMEOUT_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for a queued request at the head
// ST_ISSUE | bus transaction outstanding, bus_* held until bus_ack
// ST_RESP  | read response presented to LSU until mem_input_ready
// ST_FENCE | queue and bus drained, retire fence in one cycle
module mem_ctrl_m1 #(
  parameter int QUEUE_DEPTH    = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic          clk,
  input logic          async_rst_n,
  input logic          clk_en,
  mem_ctrl_m1_if.slave mif
);
  localparam int AW = $clog2(QUEUE_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [1:0] ST_FENCE = 2'd3;

  typedef struct packed {
    logic [14:0] addr;
    logic [1:0]  mask;
    logic [1:0]  fnc;
    logic [15:0] data;
    logic [1:0]  mode;
    logic [3:0]  dest;
  } req_t;

  req_t          fifo [QUEUE_DEPTH];
  req_t          head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;
  logic [1:0]    state;
  logic          tmo_hit;

  logic          bus_req_q, bus_we_q;
  logic [14:0]   bus_addr_q;
  logic [1:0]    bus_be_q;
  logic [15:0]   bus_wdata_q;
  logic          rack_q;
  logic [15:0]   rdata_q;
  logic [3:0]    rdest_q;

  function automatic logic [15:0] extend(input logic [15:0] w, input logic [1:0] mask,
                                         input logic [1:0] fnc);
    logic [7:0] b;
    b = (mask == 2'b10) ? w[15:8] : w[7:0];
    if (fnc[1])      return w;
    else if (fnc[0]) return {{8{b[7]}}, b};
    else             return {8'h00, b};
  endfunction

  assign head  = fifo[rd_ptr];
  assign full  = (count == (AW+1)'(QUEUE_DEPTH));
  assign empty = (count == '0);
  assign push  = clk_en && mif.mem_enable && !full;
  assign pop   = clk_en && (((state == ST_ISSUE) && (mif.bus_ack || tmo_hit)) ||
                            (state == ST_FENCE));

  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wr_ptr] <= '{addr: mif.mem_address_in, mask: mif.mem_mask_in,
                        fnc: mif.mem_read_fnc_type, data: mif.mem_data_in,
                        mode: mif.mem_mode, dest: mif.mem_wb_dest};
    end
  end

  // A pop never frees a slot for the same cycle's push; availability is count-based only.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state       <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      rack_q      <= 1'b0;
      rdata_q     <= '0;
      rdest_q     <= '0;
    end else if (clk_en) begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            if (head.mode[1]) begin
              state <= ST_FENCE;
            end else begin
              state       <= ST_ISSUE;
              bus_req_q   <= 1'b1;
              bus_we_q    <= head.mode[0];
              bus_addr_q  <= head.addr;
              bus_be_q    <= head.mask;
              bus_wdata_q <= head.data;
            end
          end
        end
        ST_ISSUE: begin
          if (mif.bus_ack || tmo_hit) begin
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            if (head.mode[0]) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_RESP;
              rack_q  <= 1'b1;
              rdata_q <= tmo_hit ? 16'hDEAD : extend(mif.bus_rdata, head.mask, head.fnc);
              rdest_q <= head.dest;
            end
          end
        end
        ST_RESP: begin
          if (mif.mem_input_ready) begin
            rack_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        ST_FENCE: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

`ifdef MEMCTL_M1_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TW-1:0] tmr;
  logic          err_q;

  // Reloaded while idle so each transaction gets exactly TIMEOUT_CYCLES request cycles.
  assign tmo_hit = (state == ST_ISSUE) && !mif.bus_ack && (tmr == '0);

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      tmr   <= '0;
      err_q <= 1'b0;
    end else if (clk_en) begin
      if (state == ST_IDLE)
        tmr <= TW'(TIMEOUT_CYCLES - 1);
      else if ((state == ST_ISSUE) && (tmr != '0))
        tmr <= tmr - 1'b1;
      if (tmo_hit) err_q <= 1'b1;
    end
  end
  assign mif.bus_err = err_q;
`else
  assign tmo_hit     = 1'b0;
  assign mif.bus_err = 1'b0;
`endif

  assign mif.bus_req         = bus_req_q;
  assign mif.bus_we          = bus_we_q;
  assign mif.bus_addr        = bus_addr_q;
  assign mif.bus_be          = bus_be_q;
  assign mif.bus_wdata       = bus_wdata_q;
  assign mif.mem_read_ack    = rack_q;
  assign mif.mem_data_out    = rdata_q;
  assign mif.mem_wb_dest_out = rdest_q;
  assign mif.mem_available   = !full;
  assign mif.mem_idle        = empty && (state == ST_IDLE);
endmodule

// File: tb/tb_mem_ctrl_m1.sv
// Self-checking bench for mem_ctrl_m1: vector table, directed corner sequences and a
// randomized run against a word-memory reference model with an expected-response queue.
`timescale 1ns/1ps
module tb_mem_ctrl_m1;
  logic clk = 1'b0;
  logic async_rst_n;
  logic clk_en;
  mem_ctrl_m1_if mif();

  mem_ctrl_m1 #(.QUEUE_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .async_rst_n(async_rst_n), .clk_en(clk_en), .mif(mif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int dly = 0;
  int addr_bad = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [1:0]  mask;
    logic [1:0]  fnc;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[12];

  typedef struct { logic [15:0] d; logic [3:0] t; } rsp_t;
  rsp_t expq[$];
  logic [15:0] model_mem[8];
  logic [15:0] bus_mem[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mif.mem_address_in = '0; mif.mem_mask_in = '0; mif.mem_read_fnc_type = '0;
    mif.mem_data_in = '0; mif.mem_mode = '0; mif.mem_enable = 1'b0; mif.mem_wb_dest = '0;
    mif.mem_input_ready = 1'b0; mif.bus_rdata = '0; mif.bus_ack = 1'b0;
  endtask

  task automatic lsu_push(input logic [1:0] mode, input logic [14:0] a, input logic [1:0] m,
                          input logic [1:0] f, input logic [15:0] d, input logic [3:0] t);
    mif.mem_mode = mode; mif.mem_address_in = a; mif.mem_mask_in = m;
    mif.mem_read_fnc_type = f; mif.mem_data_in = d; mif.mem_wb_dest = t;
    mif.mem_enable = 1'b1;
    @(negedge clk);
    mif.mem_enable = 1'b0;
  endtask

  task automatic ack_bus(input logic [15:0] rd);
    mif.bus_rdata = rd; mif.bus_ack = 1'b1;
    @(negedge clk);
    mif.bus_ack = 1'b0;
  endtask

  task automatic ready_pulse();
    mif.mem_input_ready = 1'b1;
    @(negedge clk);
    mif.mem_input_ready = 1'b0;
  endtask

  // which: 0 = bus_req, 1 = mem_read_ack, 2 = mem_idle
  task automatic wait_sig(input int which, input int lim, input string nm);
    bit hit = 1'b0;
    for (int i = 0; i < lim && !hit; i++) begin
      case (which)
        0:       hit = mif.bus_req;
        1:       hit = mif.mem_read_ack;
        default: hit = mif.mem_idle;
      endcase
      if (!hit) @(negedge clk);
    end
    chk(nm, 32'(hit), 1);
  endtask

  function automatic logic [15:0] ref_ext(input logic [15:0] w, input logic [1:0] m,
                                          input logic [1:0] f);
    int b;
    if (f >= 2) return w;
    b = (m == 2'b10) ? int'(w) / 256 : int'(w) % 256;
    if (f == 1 && b >= 128) b = b + 32'hFF00;
    return 16'(b);
  endfunction

  task automatic rand_cycle(input bit produce);
    bit ce, rdy;
    rsp_t r;
    logic [2:0] ai;
    logic [15:0] v;
    logic [1:0] md, mk, fn;
    logic [15:0] dd;
    logic [3:0] tg;
    @(negedge clk);
    ce = ($urandom_range(0, 9) != 0);
    clk_en = ce;
    mif.bus_ack = 1'b0;
    if (mif.bus_req) begin
      if (mif.bus_addr[14:3] != 12'h0C0) addr_bad++;
      if (ce) begin
        if (dly == 0) begin
          ai = mif.bus_addr[2:0];
          mif.bus_ack = 1'b1;
          if (mif.bus_we) begin
            v = bus_mem[ai];
            if (mif.bus_be[0]) v[7:0]  = mif.bus_wdata[7:0];
            if (mif.bus_be[1]) v[15:8] = mif.bus_wdata[15:8];
            bus_mem[ai] = v;
          end else begin
            mif.bus_rdata = bus_mem[ai];
          end
          dly = $urandom_range(0, 4);
        end else begin
          dly--;
        end
      end
    end else if ($urandom_range(0, 15) == 0) begin
      mif.bus_ack = 1'b1;
      mif.bus_rdata = 16'($urandom);
    end
    rdy = ($urandom_range(0, 3) != 0);
    mif.mem_input_ready = rdy;
    if (ce && rdy && mif.mem_read_ack) begin
      if (expq.size() == 0) begin
        chk("rand unexpected rsp", 32'(mif.mem_read_ack), 0);
      end else begin
        r = expq.pop_front();
        chk("rand rsp data", 32'(mif.mem_data_out), 32'(r.d));
        chk("rand rsp tag", 32'(mif.mem_wb_dest_out), 32'(r.t));
      end
    end
    mif.mem_enable = 1'b0;
    if (produce && $urandom_range(0, 2) == 0) begin
      md = 2'($urandom_range(0, 3)); ai = 3'($urandom_range(0, 7));
      mk = 2'($urandom); fn = 2'($urandom); dd = 16'($urandom); tg = 4'($urandom);
      mif.mem_mode = md; mif.mem_address_in = 15'h0600 + 15'(ai); mif.mem_mask_in = mk;
      mif.mem_read_fnc_type = fn; mif.mem_data_in = dd; mif.mem_wb_dest = tg;
      mif.mem_enable = 1'b1;
      if (ce && mif.mem_available) begin
        if (md == 2'd1) begin
          v = model_mem[ai];
          if (mk[0]) v[7:0]  = dd[7:0];
          if (mk[1]) v[15:8] = dd[15:8];
          model_mem[ai] = v;
        end else if (md == 2'd0) begin
          r.d = ref_ext(model_mem[ai], mk, fn);
          r.t = tg;
          expq.push_back(r);
        end
      end
    end
  endtask

  initial begin
    int n;
    logic [15:0] w;
    vecs[0]  = '{2'd0, 2'b10, 2'd1, 16'h0000, 16'h8034, 16'hFF80};
    vecs[1]  = '{2'd0, 2'b01, 2'd1, 16'h0000, 16'h8034, 16'h0034};
    vecs[2]  = '{2'd0, 2'b01, 2'd1, 16'h0000, 16'h12F5, 16'hFFF5};
    vecs[3]  = '{2'd0, 2'b01, 2'd0, 16'h0000, 16'h12F5, 16'h00F5};
    vecs[4]  = '{2'd0, 2'b10, 2'd0, 16'h0000, 16'hA55A, 16'h00A5};
    vecs[5]  = '{2'd0, 2'b00, 2'd1, 16'h0000, 16'hA55A, 16'h005A};
    vecs[6]  = '{2'd0, 2'b11, 2'd1, 16'h0000, 16'h7F80, 16'hFF80};
    vecs[7]  = '{2'd0, 2'b01, 2'd2, 16'h0000, 16'hBEEF, 16'hBEEF};
    vecs[8]  = '{2'd0, 2'b00, 2'd3, 16'h0000, 16'hBEEF, 16'hBEEF};
    vecs[9]  = '{2'd1, 2'b00, 2'd0, 16'h5678, 16'h0000, 16'h0000};
    vecs[10] = '{2'd1, 2'b01, 2'd0, 16'h9ABC, 16'h0000, 16'h0001};
    vecs[11] = '{2'd1, 2'b10, 2'd0, 16'hDEF0, 16'h0000, 16'h0002};

    idle_inputs();
    clk_en = 1'b1;
    async_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst read_ack", 32'(mif.mem_read_ack), 0);
    chk("rst data_out", 32'(mif.mem_data_out), 0);
    chk("rst dest_out", 32'(mif.mem_wb_dest_out), 0);
    chk("rst bus_req", 32'(mif.bus_req), 0);
    chk("rst bus_we", 32'(mif.bus_we), 0);
    chk("rst bus_addr", 32'(mif.bus_addr), 0);
    chk("rst bus_be", 32'(mif.bus_be), 0);
    chk("rst bus_wdata", 32'(mif.bus_wdata), 0);
    chk("rst bus_err", 32'(mif.bus_err), 0);
    chk("rst available", 32'(mif.mem_available), 1);
    chk("rst idle", 32'(mif.mem_idle), 1);
    async_rst_n = 1'b1;
    @(negedge clk);

    // write with ack after 3 request cycles
    lsu_push(2'd1, 15'h0010, 2'b11, 2'd0, 16'h1234, 4'd0);
    chk("wr req latency", 32'(mif.bus_req), 0);
    @(negedge clk);
    chk("wr req", 32'(mif.bus_req), 1);
    chk("wr we", 32'(mif.bus_we), 1);
    chk("wr be", 32'(mif.bus_be), 3);
    chk("wr addr", 32'(mif.bus_addr), 32'h10);
    chk("wr wdata", 32'(mif.bus_wdata), 32'h1234);
    chk("wr busy", 32'(mif.mem_idle), 0);
    repeat (2) begin
      @(negedge clk);
      chk("wr req held", 32'(mif.bus_req), 1);
      chk("wr addr held", 32'(mif.bus_addr), 32'h10);
    end
    ack_bus(16'h0000);
    chk("wr req drop", 32'(mif.bus_req), 0);
    chk("wr no rack", 32'(mif.mem_read_ack), 0);
    chk("wr idle", 32'(mif.mem_idle), 1);

    // sign-extended hi-byte read, response held while LSU not ready
    lsu_push(2'd0, 15'h0010, 2'b10, 2'd1, 16'h0000, 4'd5);
    wait_sig(0, 5, "rd req");
    chk("rd we", 32'(mif.bus_we), 0);
    ack_bus(16'h8034);
    chk("rd rack", 32'(mif.mem_read_ack), 1);
    chk("rd data", 32'(mif.mem_data_out), 32'hFF80);
    chk("rd dest", 32'(mif.mem_wb_dest_out), 5);
    repeat (2) begin
      @(negedge clk);
      chk("rd rack held", 32'(mif.mem_read_ack), 1);
      chk("rd data held", 32'(mif.mem_data_out), 32'hFF80);
    end
    ready_pulse();
    chk("rd rack released", 32'(mif.mem_read_ack), 0);
    chk("rd idle", 32'(mif.mem_idle), 1);

    // vector table
    for (int i = 0; i < 12; i++) begin
      lsu_push(vecs[i].mode, 15'h0100 + 15'(i), vecs[i].mask, vecs[i].fnc, vecs[i].wdata, 4'(i));
      wait_sig(0, 10, "tbl req");
      chk("tbl addr", 32'(mif.bus_addr), 32'h100 + 32'(i));
      chk("tbl we", 32'(mif.bus_we), 32'(vecs[i].mode == 2'd1));
      if (vecs[i].mode == 2'd1) begin
        chk("tbl be", 32'(mif.bus_be), 32'(vecs[i].exp));
        chk("tbl wdata", 32'(mif.bus_wdata), 32'(vecs[i].wdata));
      end
      ack_bus(vecs[i].rdata);
      if (vecs[i].mode == 2'd0) begin
        chk("tbl rack", 32'(mif.mem_read_ack), 1);
        chk("tbl rdata", 32'(mif.mem_data_out), 32'(vecs[i].exp));
        chk("tbl dest", 32'(mif.mem_wb_dest_out), 32'(i));
        ready_pulse();
      end else begin
        chk("tbl wr no rack", 32'(mif.mem_read_ack), 0);
      end
      wait_sig(2, 5, "tbl idle");
    end

    // fill the queue with the bus stalled, overflow requests must be dropped
    for (int k = 0; k < 4; k++)
      lsu_push(2'd1, 15'h0200 + 15'(k), 2'b11, 2'd0, 16'h1000 + 16'(k), 4'd0);
    chk("fill full", 32'(mif.mem_available), 0);
    chk("fill head addr", 32'(mif.bus_addr), 32'h200);
    lsu_push(2'd1, 15'h0255, 2'b11, 2'd0, 16'h5555, 4'd0);
    chk("fill still full", 32'(mif.mem_available), 0);
    mif.mem_address_in = 15'h0266; mif.mem_enable = 1'b1;
    ack_bus(16'h0000);
    mif.mem_enable = 1'b0;
    chk("fill slot freed", 32'(mif.mem_available), 1);
    for (int k = 1; k < 4; k++) begin
      wait_sig(0, 10, "drain req");
      chk("drain order", 32'(mif.bus_addr), 32'h200 + 32'(k));
      ack_bus(16'h0000);
    end
    wait_sig(2, 5, "drain idle");
    repeat (3) begin
      @(negedge clk);
      chk("dropped not issued", 32'(mif.bus_req), 0);
    end

    // fence waits for the preceding read to be accepted
    lsu_push(2'd1, 15'h0300, 2'b11, 2'd0, 16'hAAAA, 4'd0);
    lsu_push(2'd0, 15'h0301, 2'b11, 2'd2, 16'h0000, 4'd7);
    lsu_push(2'd2, 15'h0000, 2'b00, 2'd1, 16'h0000, 4'd0);
    lsu_push(2'd0, 15'h0302, 2'b11, 2'd2, 16'h0000, 4'd9);
    wait_sig(0, 10, "fence wr req");
    chk("fence wr addr", 32'(mif.bus_addr), 32'h300);
    ack_bus(16'h0000);
    wait_sig(0, 10, "fence rd1 req");
    chk("fence rd1 addr", 32'(mif.bus_addr), 32'h301);
    ack_bus(16'h1357);
    chk("fence rd1 data", 32'(mif.mem_data_out), 32'h1357);
    chk("fence rd1 dest", 32'(mif.mem_wb_dest_out), 7);
    repeat (4) begin
      @(negedge clk);
      chk("fence blocks rd2", 32'(mif.bus_req), 0);
      chk("fence busy", 32'(mif.mem_idle), 0);
    end
    ready_pulse();
    wait_sig(0, 10, "fence rd2 req");
    chk("fence rd2 addr", 32'(mif.bus_addr), 32'h302);
    ack_bus(16'h2468);
    chk("fence rd2 data", 32'(mif.mem_data_out), 32'h2468);
    chk("fence rd2 dest", 32'(mif.mem_wb_dest_out), 9);
    ready_pulse();
    wait_sig(2, 5, "fence idle");

    // randomized traffic against the reference model
    for (int i = 0; i < 8; i++) begin
      w = 16'($urandom);
      model_mem[i] = w;
      bus_mem[i] = w;
    end
    dly = 0;
    for (int c = 0; c < 2500; c++) rand_cycle(1'b1);
    n = 0;
    while (n < 400 && !(mif.mem_idle && expq.size() == 0)) begin
      rand_cycle(1'b0);
      n++;
    end
    chk("rand drained idle", 32'(mif.mem_idle), 1);
    chk("rand rsp left", 32'(expq.size()), 0);
    chk("rand addr range", 32'(addr_bad), 0);
    for (int i = 0; i < 8; i++) chk("rand mem word", 32'(bus_mem[i]), 32'(model_mem[i]));
    chk("rand no bus_err", 32'(mif.bus_err), 0);
    idle_inputs();
    clk_en = 1'b1;
    @(negedge clk);

    // asynchronous reset during an outstanding read
    lsu_push(2'd0, 15'h0400, 2'b11, 2'd2, 16'h0000, 4'd1);
    lsu_push(2'd1, 15'h0401, 2'b11, 2'd0, 16'h0000, 4'd0);
    wait_sig(0, 5, "rst txn req");
    #2 async_rst_n = 1'b0;
    #1;
    chk("rst mid bus_req", 32'(mif.bus_req), 0);
    chk("rst mid idle", 32'(mif.mem_idle), 1);
    chk("rst mid available", 32'(mif.mem_available), 1);
    @(negedge clk);
    async_rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post rst no req", 32'(mif.bus_req), 0);
      chk("post rst idle", 32'(mif.mem_idle), 1);
    end

`ifdef MEMCTL_M1_TIMEOUT_EN
    lsu_push(2'd0, 15'h0500, 2'b11, 2'd2, 16'h0000, 4'd3);
    wait_sig(0, 5, "tmo req");
    n = 0;
    while (mif.bus_req && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("tmo req cycles", 32'(n), 8);
    chk("tmo rack", 32'(mif.mem_read_ack), 1);
    chk("tmo data", 32'(mif.mem_data_out), 32'hDEAD);
    chk("tmo dest", 32'(mif.mem_wb_dest_out), 3);
    chk("tmo err", 32'(mif.bus_err), 1);
    ready_pulse();
    chk("tmo err sticky", 32'(mif.bus_err), 1);
    wait_sig(2, 5, "tmo idle");
`else
    lsu_push(2'd0, 15'h0500, 2'b11, 2'd2, 16'h0000, 4'd3);
    repeat (20) @(negedge clk);
    chk("no tmo req held", 32'(mif.bus_req), 1);
    chk("no tmo err", 32'(mif.bus_err), 0);
    ack_bus(16'h0042);
    chk("no tmo late data", 32'(mif.mem_data_out), 32'h0042);
    ready_pulse();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
